// File: rtl/mips5_pipeline_cpu.sv
// Five-stage MIPS-I subset core (IF/ID/EX/MEM/WB) with private instruction memory,
// register file and data memory. No forwarding or interlocks; one branch delay slot.

module mips5_if #(
    parameter int IMEM_WORDS = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_i,
    input  logic [31:0]                   target_i,
    input  logic                          load_we_i,
    input  logic [$clog2(IMEM_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                   load_data_i,
    output logic [31:0]                   pc_o,
    output logic [31:0]                   instr_o
);
    localparam int AW = $clog2(IMEM_WORDS);

    logic [31:0] instruction [IMEM_WORDS];
    logic [31:0] PC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) PC <= '0;
        else     PC <= redirect_i ? target_i : PC + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (load_we_i) instruction[load_addr_i] <= load_data_i;
    end

    assign pc_o    = PC;
    assign instr_o = instruction[PC[AW+1:2]];
endmodule

module mips5_id (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] REG [32];

    always_ff @(posedge clk) begin
        if (we_i && waddr_i != 5'd0) REG[waddr_i] <= wdata_i;
    end

    // Same-cycle write-back is visible to decode, so WB and ID may overlap.
    function automatic logic [31:0] rd(input logic [4:0] a, input logic [31:0] mem_val);
        if (a == 5'd0)                return '0;
        else if (we_i && waddr_i == a) return wdata_i;
        else                          return mem_val;
    endfunction

    assign rdata1_o = rd(raddr1_i, REG[raddr1_i]);
    assign rdata2_o = rd(raddr2_i, REG[raddr2_i]);
endmodule

module mips5_mem #(
    parameter int DMEM_WORDS = 128
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [$clog2(DMEM_WORDS)-1:0] addr_i,
    input  logic [31:0]                   wdata_i,
    output logic [31:0]                   rdata_o
);
    logic [31:0] DM [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) DM[addr_i] <= wdata_i;
    end

    assign rdata_o = DM[addr_i];
endmodule

module mips5_pipeline_cpu #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128
) (
    input logic clk,
    input logic rst
);
    localparam int DAW = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    function automatic logic [31:0] alu(input alu_op_e op, input logic signed [31:0] a,
                                        input logic signed [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, a < b};
            default: return a + b;
        endcase
    endfunction

    logic [31:0] pc, instr, rd1, rd2, dm_rdata;
    logic        redirect;
    logic [31:0] target;

    logic [31:0] FD_PC, fd_instr_q;
    logic [31:0] de_a_q, de_b_q, de_imm_q;
    logic [4:0]  de_dest_q;
    logic        de_we_q, de_mr_q, de_mw_q, de_use_imm_q;
    alu_op_e     de_alu_q;
    logic [31:0] em_res_q, em_st_q;
    logic [4:0]  em_dest_q;
    logic        em_we_q, em_mr_q, em_mw_q;
    logic [31:0] mw_data_q;
    logic [4:0]  mw_dest_q;
    logic        mw_we_q;

    mips5_if #(.IMEM_WORDS(IMEM_WORDS)) IF (
        .clk(clk), .rst(rst), .redirect_i(redirect), .target_i(target),
        .load_we_i(1'b0), .load_addr_i('0), .load_data_i('0),
        .pc_o(pc), .instr_o(instr)
    );

    mips5_id ID (
        .clk(clk), .we_i(mw_we_q), .waddr_i(mw_dest_q), .wdata_i(mw_data_q),
        .raddr1_i(fd_instr_q[25:21]), .raddr2_i(fd_instr_q[20:16]),
        .rdata1_o(rd1), .rdata2_o(rd2)
    );

    mips5_mem #(.DMEM_WORDS(DMEM_WORDS)) MEM (
        .clk(clk), .we_i(em_mw_q), .addr_i(em_res_q[DAW+1:2]), .wdata_i(em_st_q),
        .rdata_o(dm_rdata)
    );

    logic [5:0]  op, funct;
    logic [31:0] imm_sext;
    logic [4:0]  dest_d;
    logic        we_d, mr_d, mw_d, use_imm_d;
    alu_op_e     alu_d;

    assign op       = fd_instr_q[31:26];
    assign funct    = fd_instr_q[5:0];
    assign imm_sext = {{16{fd_instr_q[15]}}, fd_instr_q[15:0]};

    always_comb begin
        we_d      = 1'b0;
        mr_d      = 1'b0;
        mw_d      = 1'b0;
        use_imm_d = 1'b0;
        dest_d    = fd_instr_q[15:11];
        alu_d     = ALU_ADD;
        redirect  = 1'b0;
        target    = FD_PC + (imm_sext << 2);
        case (op)
            6'h00: begin
                we_d = 1'b1;
                case (funct)
                    6'h20:   alu_d = ALU_ADD;
                    6'h22:   alu_d = ALU_SUB;
                    6'h24:   alu_d = ALU_AND;
                    6'h25:   alu_d = ALU_OR;
                    6'h2a:   alu_d = ALU_SLT;
                    default: we_d  = 1'b0;
                endcase
            end
            6'h23: begin
                we_d = 1'b1; mr_d = 1'b1; use_imm_d = 1'b1; dest_d = fd_instr_q[20:16];
            end
            6'h2b: begin
                mw_d = 1'b1; use_imm_d = 1'b1;
            end
            6'h04: redirect = (rd1 == rd2);
            6'h02: begin
                redirect = 1'b1;
                target   = {FD_PC[31:28], fd_instr_q[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FD_PC        <= '0;
            fd_instr_q   <= '0;
            de_a_q       <= '0;
            de_b_q       <= '0;
            de_imm_q     <= '0;
            de_dest_q    <= '0;
            de_we_q      <= 1'b0;
            de_mr_q      <= 1'b0;
            de_mw_q      <= 1'b0;
            de_use_imm_q <= 1'b0;
            de_alu_q     <= ALU_ADD;
            em_res_q     <= '0;
            em_st_q      <= '0;
            em_dest_q    <= '0;
            em_we_q      <= 1'b0;
            em_mr_q      <= 1'b0;
            em_mw_q      <= 1'b0;
            mw_data_q    <= '0;
            mw_dest_q    <= '0;
            mw_we_q      <= 1'b0;
        end else begin
            // IF -> ID
            FD_PC        <= pc + 32'd4;
            fd_instr_q   <= instr;
            // ID -> EX
            de_a_q       <= rd1;
            de_b_q       <= rd2;
            de_imm_q     <= imm_sext;
            de_dest_q    <= dest_d;
            de_we_q      <= we_d;
            de_mr_q      <= mr_d;
            de_mw_q      <= mw_d;
            de_use_imm_q <= use_imm_d;
            de_alu_q     <= alu_d;
            // EX -> MEM
            em_res_q     <= alu(de_alu_q, de_a_q, de_use_imm_q ? de_imm_q : de_b_q);
            em_st_q      <= de_b_q;
            em_dest_q    <= de_dest_q;
            em_we_q      <= de_we_q;
            em_mr_q      <= de_mr_q;
            em_mw_q      <= de_mw_q;
            // MEM -> WB
            mw_data_q    <= em_mr_q ? dm_rdata : em_res_q;
            mw_dest_q    <= em_dest_q;
            mw_we_q      <= em_we_q;
        end
    end
endmodule

// File: tb/tb_mips5_pipeline_cpu.sv
// Directed program bench for mips5_pipeline_cpu: expected write-backs are queued by the
// stimulus and a monitor checks each register write as it leaves the pipeline.

module tb_mips5_pipeline_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;

    mips5_pipeline_cpu dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] v;
    } wb_t;

    wb_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  max_fd  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic expect_wb(input int r, input logic [31:0] v);
        wb_t e;
        e.r = 5'(r);
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 128; i++) dut.IF.instruction[i] = 32'd0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every architectural register write must match the head of the queue.
    always @(negedge clk) begin
        if ((dut.FD_PC >> 2) > max_fd) max_fd = int'(dut.FD_PC >> 2);
        if (dut.mw_we_q && dut.mw_dest_q != 5'd0) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got r%0d=0x%08h, expected no write",
                         dut.mw_dest_q, dut.mw_data_q);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_reg", 32'(dut.mw_dest_q), 32'(e.r));
                check("wb_data", dut.mw_data_q, e.v);
            end
        end
    end

    initial begin
        // Load/add/jump loop
        clear_imem();
        dut.MEM.DM[0] = 32'd9;
        dut.ID.REG[2] = 32'd2;
        dut.ID.REG[3] = 32'd0;
        dut.IF.instruction[0]  = itype(6'h23, 0, 3, 16'd0);
        dut.IF.instruction[4]  = rtype(2, 3, 3, 6'h20);
        dut.IF.instruction[9]  = {6'h02, 26'd4};
        dut.IF.instruction[13] = rtype(2, 3, 3, 6'h2a);
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_pc", dut.IF.PC, 32'd0);
        check("reset_fd_pc", dut.FD_PC, 32'd0);
        check("reset_wb_we", 32'(dut.mw_we_q), 32'd0);
        expect_wb(3, 32'd9);
        expect_wb(3, 32'd11);
        expect_wb(3, 32'd13);
        expect_wb(3, 32'd15);
        max_fd = 0;
        rst = 1'b0;
        run(23);
        check("loop_reg3", dut.ID.REG[3], 32'd15);
        check("loop_fd_pc_bound", 32'(max_fd), 32'd11);
        check("loop_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of the loop
        #1;
        rst = 1'b1;
        #1;
        check("async_pc", dut.IF.PC, 32'd0);
        check("async_fd_pc", dut.FD_PC, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("keep_reg3", dut.ID.REG[3], 32'd15);
        check("keep_dm0", dut.MEM.DM[0], 32'd9);
        expect_wb(3, 32'd9);
        expect_wb(3, 32'd11);
        rst = 1'b0;
        run(9);
        check("restart_reg3", dut.ID.REG[3], 32'd11);
        check("restart_drain", 32'(exp_q.size()), 32'd0);

        // Store then load
        clear_imem();
        dut.ID.REG[5] = 32'd0;
        dut.IF.instruction[0] = itype(6'h2b, 0, 2, 16'd4);
        dut.IF.instruction[4] = itype(6'h23, 0, 5, 16'd4);
        expect_wb(5, 32'd2);
        reset_pulse();
        run(12);
        check("sw_dm1", dut.MEM.DM[1], 32'd2);
        check("lw_reg5", dut.ID.REG[5], 32'd2);
        check("swlw_drain", 32'(exp_q.size()), 32'd0);

        // Taken branch with delay slot
        clear_imem();
        dut.ID.REG[4] = 32'd0;
        dut.ID.REG[8] = 32'd0;
        dut.ID.REG[9] = 32'd0;
        dut.IF.instruction[0] = itype(6'h04, 0, 0, 16'd2);
        dut.IF.instruction[1] = rtype(2, 2, 4, 6'h20);
        dut.IF.instruction[2] = rtype(2, 2, 8, 6'h20);
        dut.IF.instruction[3] = rtype(2, 0, 9, 6'h20);
        expect_wb(4, 32'd4);
        expect_wb(9, 32'd2);
        reset_pulse();
        run(10);
        check("beq_slot_reg4", dut.ID.REG[4], 32'd4);
        check("beq_skip_reg8", dut.ID.REG[8], 32'd0);
        check("beq_target_reg9", dut.ID.REG[9], 32'd2);
        check("beq_drain", 32'(exp_q.size()), 32'd0);

        // r0 immutability and ALU operations
        clear_imem();
        dut.ID.REG[1] = 32'd1;
        dut.IF.instruction[0] = rtype(2, 2, 0, 6'h20);
        dut.IF.instruction[1] = rtype(0, 1, 6, 6'h2a);
        dut.IF.instruction[2] = rtype(0, 1, 7, 6'h22);
        dut.IF.instruction[3] = rtype(2, 1, 11, 6'h24);
        dut.IF.instruction[4] = rtype(2, 1, 12, 6'h25);
        dut.IF.instruction[6] = rtype(7, 0, 13, 6'h2a);
        expect_wb(6, 32'd1);
        expect_wb(7, 32'hFFFF_FFFF);
        expect_wb(11, 32'd0);
        expect_wb(12, 32'd3);
        expect_wb(13, 32'd1);
        reset_pulse();
        run(12);
        check("r0_zero", dut.ID.REG[0], 32'd0);
        check("sub_reg7", dut.ID.REG[7], 32'hFFFF_FFFF);
        check("slt_signed_reg13", dut.ID.REG[13], 32'd1);
        check("alu_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end
endmodule
